bitmask_assembler: RTL and testbench

Sequential index-to-bitmask decoder for the KGP_RISC datapath: it accepts a stream of bit indices over a valid/ready handshake, sets the corresponding bits in a WIDTH-bit accumulator, and presents the assembled word on a second valid/ready port. It is the inverse of the lowest-set-bit index encoder already in the execute stage: that block maps a word to a bit position, and this block maps bit positions back to a word. It feeds mask-generation and register-writeback paths, and is used to build operand masks over several cycles.

---
 rtl/bitmask_assembler_if.sv | 29 ++
 rtl/bitmask_assembler.sv | 100 ++++++++++
 tb/tb_bitmask_assembler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bitmask_assembler_if.sv
// Handshake bundle between an index producer, the bitmask assembler and the
// consumer of the assembled word.
interface bitmask_assembler_if #(
    parameter int WIDTH = 32
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             in_last;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [IDX_W:0]   out_count;
    logic             out_dup;
    logic             out_empty;

    modport master (
        output in_valid, in_index, in_last, in_flush, out_ready,
        input  in_ready, out_valid, out_word, out_count, out_dup, out_empty
    );

    modport slave (
        input  in_valid, in_index, in_last, in_flush, out_ready,
        output in_ready, out_valid, out_word, out_count, out_dup, out_empty
    );
endinterface

// File: rtl/bitmask_assembler.sv
// Sequential index-to-bitmask decoder: ORs one-hot bits into an accumulator
// per accepted index beat and presents the assembled word with its distinct
// bit count and a duplicate flag.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | accumulator empty, no beat taken yet
//   ACCUM | at least one beat folded into the accumulator
//   HOLD  | assembled word presented, waiting for out_ready
module bitmask_assembler #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    bitmask_assembler_if.slave bus
);
    localparam int             IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IDX_W:0]   cnt;
    logic             dup;

    logic             can_take;
    logic             take;
    logic             hit;
    logic             pkt_end;
    logic [WIDTH-1:0] bit_sel;
    logic [WIDTH-1:0] acc_nxt;
    logic [IDX_W:0]   cnt_nxt;
    logic             dup_nxt;

    // in_ready depends on state only; rst_n gates it so it is low while reset is held.
    assign can_take     = (state != HOLD);
    assign bus.in_ready = rst_n & can_take;

    // Post-update accumulator values for the beat (if any) offered this cycle.
    always_comb begin
        take    = bus.in_valid & can_take;
        bit_sel = WIDTH'(1) << bus.in_index;
        hit     = take & ((acc & bit_sel) != '0);
        acc_nxt = take ? (acc | bit_sel) : acc;
        cnt_nxt = (take & ~hit) ? (cnt + CNT_ONE) : cnt;
        dup_nxt = dup | hit;
        pkt_end = (take & bus.in_last) | (can_take & bus.in_flush);
    end

    // Packet FSM with accumulator and registered output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            dup           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_word  <= '0;
            bus.out_count <= '0;
            bus.out_dup   <= 1'b0;
            bus.out_empty <= 1'b1;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    dup <= dup_nxt;
                    if (pkt_end) begin
                        bus.out_valid <= 1'b1;
                        bus.out_word  <= acc_nxt;
                        bus.out_count <= cnt_nxt;
                        bus.out_dup   <= dup_nxt;
                        bus.out_empty <= (acc_nxt == '0);
                        state         <= HOLD;
                    end else if (take) begin
                        state <= ACCUM;
                    end
                end
                HOLD: begin
                    // out_* keep their values after the handshake; out_valid qualifies them.
                    if (bus.out_ready) begin
                        acc           <= '0;
                        cnt           <= '0;
                        dup           <= 1'b0;
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitmask_assembler.sv
// Self-checking bench for bitmask_assembler: directed vector table, corner
// sequences, then randomized traffic against a packet-level reference model.
module tb_bitmask_assembler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bitmask_assembler_if #(.WIDTH(32)) bus ();

    bitmask_assembler #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  idx;
        logic        last;
        logic        flush;
        logic        ordy;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_word;
        logic [5:0]  e_cnt;
        logic        e_dup;
        logic        e_empty;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_valid, input logic e_ready,
                           input logic [31:0] e_word, input logic [5:0] e_cnt,
                           input logic e_dup, input logic e_empty);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(e_valid));
        chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(e_ready));
        chk({tag, ".out_word"},  64'(bus.out_word),  64'(e_word));
        chk({tag, ".out_count"}, 64'(bus.out_count), 64'(e_cnt));
        chk({tag, ".out_dup"},   64'(bus.out_dup),   64'(e_dup));
        chk({tag, ".out_empty"}, 64'(bus.out_empty), 64'(e_empty));
    endtask

    // Apply inputs, take one rising edge, return 1 time unit after it.
    task automatic drive(input logic v, input logic [4:0] idx, input logic last,
                         input logic flush, input logic ordy);
        bus.in_valid  = v;
        bus.in_index  = idx;
        bus.in_last   = last;
        bus.in_flush  = flush;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_word;
        logic [5:0]  m_cnt;
        logic        m_dup;
        logic        m_empty;
        logic        m_hold;
        int          pkt[$];
        int          pulses;

        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.in_index  = '0;
        bus.in_last   = 1'b0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b0;

        //         v  idx  lst fl ordy | valid rdy  word          cnt dup empty
        tbl[0]  = '{1, 5'd0,  0, 0, 1,   0, 1, 32'h0000_0000, 6'd0, 0, 1};
        tbl[1]  = '{1, 5'd5,  0, 0, 1,   0, 1, 32'h0000_0000, 6'd0, 0, 1};
        tbl[2]  = '{1, 5'd31, 1, 0, 1,   1, 0, 32'h8000_0021, 6'd3, 0, 0};
        tbl[3]  = '{0, 5'd0,  0, 0, 1,   0, 1, 32'h8000_0021, 6'd3, 0, 0};
        tbl[4]  = '{1, 5'd3,  0, 0, 1,   0, 1, 32'h8000_0021, 6'd3, 0, 0};
        tbl[5]  = '{1, 5'd3,  0, 0, 1,   0, 1, 32'h8000_0021, 6'd3, 0, 0};
        tbl[6]  = '{1, 5'd7,  1, 0, 1,   1, 0, 32'h0000_0088, 6'd2, 1, 0};
        tbl[7]  = '{0, 5'd0,  0, 0, 1,   0, 1, 32'h0000_0088, 6'd2, 1, 0};
        tbl[8]  = '{0, 5'd0,  0, 1, 1,   1, 0, 32'h0000_0000, 6'd0, 0, 1};
        tbl[9]  = '{0, 5'd0,  0, 0, 1,   0, 1, 32'h0000_0000, 6'd0, 0, 1};
        tbl[10] = '{1, 5'd4,  0, 1, 1,   1, 0, 32'h0000_0010, 6'd1, 0, 0};
        tbl[11] = '{0, 5'd0,  0, 0, 1,   0, 1, 32'h0000_0010, 6'd1, 0, 0};

        // Reset state, sampled while rst_n is still low.
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("reset", 1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("reset_release.in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].idx, tbl[i].last, tbl[i].flush, tbl[i].ordy);
            chk_out($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_ready,
                    tbl[i].e_word, tbl[i].e_cnt, tbl[i].e_dup, tbl[i].e_empty);
        end

        // Backpressure: producer holds index 9 while output is stalled.
        drive(1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk_out("bp_end", 1'b1, 1'b0, 32'h0000_0204, 6'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
            chk_out($sformatf("bp_stall%0d", i), 1'b1, 1'b0, 32'h0000_0204, 6'd2, 1'b0, 1'b0);
        end
        drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        chk_out("bp_release", 1'b0, 1'b1, 32'h0000_0204, 6'd2, 1'b0, 1'b0);
        drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk_out("bp_next", 1'b1, 1'b0, 32'h0000_0200, 6'd1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Full mask: every index once.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), (i == 31), 1'b0, 1'b0);
        end
        chk_out("full", 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Reset mid-packet discards the partial accumulator.
        drive(1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd11, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready_low", 64'(bus.in_ready), 64'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("midrst", 1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("midrst.in_ready_high", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b1);
        chk_out("midrst_next", 1'b1, 1'b0, 32'h0000_0002, 6'd1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Back-to-back single-beat packets with out_ready tied high.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i), 1'b1, 1'b0, 1'b1);
            if (bus.out_valid === 1'b1) pulses++;
            chk($sformatf("b2b%0d.out_valid", i), 64'(bus.out_valid), 64'((i % 2) == 0));
            chk($sformatf("b2b%0d.in_ready", i), 64'(bus.in_ready), 64'((i % 2) == 1));
            if ((i % 2) == 0) begin
                chk($sformatf("b2b%0d.out_word", i), 64'(bus.out_word), 64'(32'h1 << i));
            end
        end
        chk("b2b.pulses", 64'(pulses), 64'd4);

        // Randomized traffic against a packet-level model.
        do_reset();
        m_hold  = 1'b0;
        m_word  = 32'h0;
        m_cnt   = 6'd0;
        m_dup   = 1'b0;
        m_empty = 1'b1;
        pkt.delete();
        for (int c = 0; c < 3000; c++) begin
            logic       v, last, fl, ordy;
            logic [4:0] idx;
            v    = 1'($urandom_range(0, 1));
            idx  = 5'($urandom_range(0, 31));
            last = ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            ordy = 1'($urandom_range(0, 1));
            if (!m_hold) begin
                if (v) pkt.push_back(int'(idx));
                if ((v && last) || fl) begin
                    m_word = 32'h0;
                    foreach (pkt[j]) m_word = m_word | (32'h1 << pkt[j]);
                    m_cnt   = 6'($countones(m_word));
                    m_dup   = (pkt.size() > int'(m_cnt));
                    m_empty = (m_word == 32'h0);
                    m_hold  = 1'b1;
                end
            end else if (ordy) begin
                m_hold = 1'b0;
                pkt.delete();
            end
            drive(v, idx, last, fl, ordy);
            chk_out($sformatf("rand%0d", c), m_hold, ~m_hold, m_word, m_cnt, m_dup, m_empty);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
